// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg: shared definitions for the data-memory load/store unit.
//   - RV32I funct3 width/sign encodings
//   - transaction state encoding
//   - alignment and legality helpers used when an op is presented
package dmem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    // funct3[1:0] carries the access size for both loads and stores.
    function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        case (f3[1:0])
            2'b00:   ok = 1'b1;
            2'b01:   ok = ~off[0];
            2'b10:   ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Unsigned variants exist only for loads.
    function automatic logic is_legal(input logic ld, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ld;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// dmem_lsu_align: combinational lane logic for the load/store unit.
//   Store side: st_funct3/st_off/st_data/st_is_store -> st_be, st_wdata
//               (byte enables and lane-replicated write data).
//   Load side:  ld_funct3/ld_off/ld_rdata -> ld_data
//               (lane select plus sign/zero extension).
module dmem_lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic        st_is_store,
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store byte enables and replicated data; loads always fetch the full word.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        if (st_is_store) begin
            case (st_funct3)
                F3_B: begin
                    st_be    = 4'b0001 << st_off;
                    st_wdata = {4{st_data[7:0]}};
                end
                F3_H: begin
                    st_be    = st_off[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{st_data[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = st_data;
                end
            endcase
        end else begin
            st_be    = 4'b1111;
            st_wdata = st_data;
        end
    end

    // Load lane select followed by sign or zero extension.
    always_comb begin
        case (ld_off)
            2'd0:    byte_s = ld_rdata[7:0];
            2'd1:    byte_s = ld_rdata[15:8];
            2'd2:    byte_s = ld_rdata[23:16];
            default: byte_s = ld_rdata[31:24];
        endcase
        half_s = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_funct3)
            F3_B:    ld_data = {{24{byte_s[7]}}, byte_s};
            F3_BU:   ld_data = {24'h000000, byte_s};
            F3_H:    ld_data = {{16{half_s[15]}}, half_s};
            F3_HU:   ld_data = {16'h0000, half_s};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: memory-stage load/store unit, initiator on the data-memory bus.
//   Pipeline side: op_valid, is_load, is_store, funct3, addr, store_data in;
//                  stall, load_valid, load_data, misaligned, bus_err out.
//   Memory side:   mem_req, mem_we, mem_be, mem_addr, mem_wdata out;
//                  mem_gnt, mem_rvalid, mem_rdata in.
//   TIMEOUT bounds the cycles spent in REQ+WAIT (0 disables it).
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              stall,
    output logic              load_valid,
    output logic [31:0]       load_data,
    output logic              misaligned,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam int               CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit               TO_EN   = (TIMEOUT > 0);

    state_t              state_r, state_nxt_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
    logic                op_kind_s, op_ok_s, accept_s, reject_s, busy_s, to_hit_s;
    logic                req_nxt_s, load_valid_nxt_s, bus_err_nxt_s;
    logic [31:0]         load_data_nxt_s;
    logic [3:0]          st_be_s;
    logic [31:0]         st_wdata_s, ld_ext_s;

    logic                mem_req_r, mem_we_r, load_valid_r, bus_err_r, ld_r;
    logic [3:0]          mem_be_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [31:0]         mem_wdata_r, load_data_r;
    logic [1:0]          ld_off_r;
    logic [2:0]          ld_f3_r;

    dmem_lsu_align u_align (
        .st_is_store (is_store),
        .st_funct3   (funct3),
        .st_off      (addr[1:0]),
        .st_data     (store_data),
        .st_be       (st_be_s),
        .st_wdata    (st_wdata_s),
        .ld_funct3   (ld_f3_r),
        .ld_off      (ld_off_r),
        .ld_rdata    (mem_rdata),
        .ld_data     (ld_ext_s)
    );

    // Classify the presented op and detect the timeout limit.
    always_comb begin
        op_kind_s = op_valid & (is_load | is_store);
        op_ok_s   = is_aligned(funct3, addr[1:0]) & is_legal(is_load, funct3);
        accept_s  = (state_r == IDLE) & op_kind_s & op_ok_s;
        reject_s  = (state_r == IDLE) & op_kind_s & ~op_ok_s;
        busy_s    = (state_r == REQ) | (state_r == WAIT);
        to_hit_s  = TO_EN & busy_s & (cnt_r == TO_LAST);
    end

    // Next-state and next-register values; handshake progress beats the timeout.
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        req_nxt_s        = mem_req_r;
        load_valid_nxt_s = 1'b0;
        bus_err_nxt_s    = 1'b0;
        load_data_nxt_s  = load_data_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = REQ;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    req_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                cnt_nxt_s = cnt_r + CNT_W'(1'b1);
                if (mem_gnt) begin
                    req_nxt_s = 1'b0;
                    if (!ld_r) begin
                        state_nxt_s = RESP;
                    end else if (mem_rvalid) begin
                        state_nxt_s      = RESP;
                        load_data_nxt_s  = ld_ext_s;
                        load_valid_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = WAIT;
                    end
                end else if (to_hit_s) begin
                    req_nxt_s       = 1'b0;
                    state_nxt_s     = RESP;
                    bus_err_nxt_s   = 1'b1;
                    load_data_nxt_s = 32'h0000_0000;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            WAIT: begin
                cnt_nxt_s = cnt_r + CNT_W'(1'b1);
                if (mem_rvalid) begin
                    state_nxt_s      = RESP;
                    load_data_nxt_s  = ld_ext_s;
                    load_valid_nxt_s = 1'b1;
                end else if (to_hit_s) begin
                    state_nxt_s     = RESP;
                    bus_err_nxt_s   = 1'b1;
                    load_data_nxt_s = 32'h0000_0000;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath registers; request fields are captured only when an op is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r        <= {CNT_W{1'b0}};
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_be_r     <= 4'b0000;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= 32'h0000_0000;
            load_valid_r <= 1'b0;
            bus_err_r    <= 1'b0;
            load_data_r  <= 32'h0000_0000;
            ld_r         <= 1'b0;
            ld_off_r     <= 2'b00;
            ld_f3_r      <= 3'b000;
        end else begin
            cnt_r        <= cnt_nxt_s;
            mem_req_r    <= req_nxt_s;
            load_valid_r <= load_valid_nxt_s;
            bus_err_r    <= bus_err_nxt_s;
            load_data_r  <= load_data_nxt_s;
            if (accept_s) begin
                mem_we_r    <= is_store;
                mem_be_r    <= st_be_s;
                mem_addr_r  <= {addr[ADDR_W-1:2], 2'b00};
                mem_wdata_r <= st_wdata_s;
                ld_r        <= is_load;
                ld_off_r    <= addr[1:0];
                ld_f3_r     <= funct3;
            end
        end
    end

    // stall and misaligned are combinational so the pipeline reacts in the op's own cycle.
    assign stall      = ~reset & (accept_s | busy_s);
    assign misaligned = ~reset & reject_s;
    assign load_valid = load_valid_r;
    assign load_data  = load_data_r;
    assign bus_err    = bus_err_r;
    assign mem_req    = mem_req_r;
    assign mem_we     = mem_we_r;
    assign mem_be     = mem_be_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;

endmodule
